digit_stream_accumulator: RTL and testbench
===========================================

Name: digit_stream_accumulator

Overview:
- Parametrised successor to the byte-digit concatenator that sits behind the UART receiver.
- Converts an MSB-first stream of digit bytes (ASCII or raw) into a binary integer, closed by a terminator strobe.
- Accumulates with Horner's rule (acc = acc*RADIX + digit), so no FIFO and no power table are needed.
- Adds configurable radix, width and digit limit, optional leading minus sign, and error/overflow reporting.

Parameters:
- RESULT_W, 32: width of resultado in bits; two's complement when SIGNED=1.
- RADIX, 10: numeric base, 2..16.
- MAX_DIGITS, 10: maximum digits accepted per number; 1..31.
- ASCII_MODE, 1: 1 = dato is ASCII ('0'-'9', 'A'-'F'/'a'-'f'); 0 = dato is the raw digit value.
- SIGNED, 0: 1 = a '-' (0x2D) as the first byte negates the result. Valid only with ASCII_MODE=1.

Ports:
- clk, input, 1: single clock; all logic is posedge.
- reset, input, 1: synchronous, active-high reset.
- dato, input, 8: incoming character/digit byte.
- num_ready, input, 1: byte-valid level from the UART; a byte is taken on its 0->1 transition only.
- fin, input, 1: terminator level; sampled on its 0->1 transition only.
- resultado, output, RESULT_W: registered final value.
- done, output, 1: one-cycle pulse when resultado is updated.
- error, output, 1: valid with done; 1 = invalid digit or overflow seen.
- digit_count, output, 5: digits accepted for the current number; live.

Behaviour:
- Reset (reset=1 at posedge): resultado=0, done=0, error=0, digit_count=0, accumulator=0, sign=0, error-latch=0, state=IDLE, edge-detector history regs=0.
- reset asserted mid-number discards all partial state; no done is produced.
- Edge detection:
  - num_ready and fin are registered.
  - A strobe is (current & ~previous), so a held level counts once.
  - Both strobes rising in the same cycle: the byte is processed first, then the terminate sequence runs in the same cycle (the byte is included).
- State IDLE:
  - On a byte strobe, go to ACCUM and process the byte.
  - On a fin strobe with no digits, go to EMIT with resultado=0 and error=1 (empty number).
- State ACCUM, per byte strobe:
  - Decode: value = dato-'0', or dato-'A'+10 / dato-'a'+10 in ASCII mode; value = dato in raw mode.
  - Digit valid iff value < RADIX.
  - '-' is accepted only when SIGNED=1 and digit_count==0 and no sign is yet set; it sets sign and increments nothing.
  - Any other invalid byte sets error-latch and leaves the accumulator unchanged.
  - Valid digit: the accumulator is RESULT_W+8 bits wide, and acc <= acc*RADIX + value; digit_count++.
  - Overflow: set error-latch if digit_count would exceed MAX_DIGITS, or if the accumulator exceeds 2^RESULT_W-1 (2^(RESULT_W-1) when sign=1, otherwise 2^(RESULT_W-1)-1 when SIGNED=1).
  - After overflow, further digits are counted but the accumulator is frozen.
- fin strobe in ACCUM -> EMIT.
- State EMIT, exactly 1 cycle:
  - resultado <= sign ? -acc[RESULT_W-1:0] : acc[RESULT_W-1:0].
  - On error, resultado <= 0.
  - error <= error-latch; done <= 1.
  - Next state CLEAR.
- State CLEAR, 1 cycle:
  - done <= 0; accumulator, sign, error-latch and digit_count cleared.
  - Next state IDLE.
  - Byte or fin strobes arriving in EMIT/CLEAR are dropped.
- Latency: fin rising edge at input -> done high 3 clk later (1 sync register + ACCUM->EMIT + output register).
- resultado holds its value until the next EMIT; error is valid only while done=1 and holds until the next EMIT.

Decomposition:
- Package dsa_pkg holds:
  - state encoding localparams: IDLE, ACCUM, EMIT, CLEAR (one-hot, 4 bits);
  - ASCII constants: CHAR_0=0x30, CHAR_A=0x41, CHAR_a=0x61, CHAR_MINUS=0x2D.
- One natural sub-module: digit_decoder, combinational.
  - Parameterised by RADIX and ASCII_MODE.
  - Inputs: dato. Outputs: value[4:0], is_digit, is_minus.
  - The FSM, edge detect and accumulator stay in the top level.

Test Plan:
- Defaults; bytes "1","2","3","4" (each num_ready held 4 clk), then fin -> done pulse 1 clk, resultado=1234, error=0, exactly 3 clk after fin rises.
- SIGNED=1; "-","4","2",fin -> resultado=0xFFFFFFD6 (-42), error=0. Then "7",fin -> resultado=7: state fully cleared between numbers.
- RADIX=16, RESULT_W=16; "F","f","0","1",fin -> resultado=0xFF01. Then "1","0","0","0","0",fin -> error=1, resultado=0 (overflow).
- Defaults; "1","x","2",fin -> error=1, resultado=0. fin alone from IDLE -> done=1, error=1, resultado=0.
- num_ready held high 20 clk with dato="5", then fin -> resultado=5 (single capture). num_ready and fin rising together on "9" after "8" -> resultado=89.
- Send "1","2", assert reset 1 clk, then "3",fin -> resultado=3, and no done during or after reset until this fin.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared encodings for the digit stream accumulator: one-hot FSM states and
// the ASCII code points the decoder recognises.
package dsa_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ACCUM = 4'b0010,
    EMIT  = 4'b0100,
    CLEAR = 4'b1000
  } state_e;

  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_A     = 8'h41;
  localparam logic [7:0] CHAR_a     = 8'h61;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;

endpackage

// File: rtl/digit_decoder.sv
// Combinational byte-to-digit decoder. An unrecognised byte decodes to 31,
// which is never below any legal radix, so is_digit reduces to one compare.
module digit_decoder
  import dsa_pkg::*;
#(
  parameter int RADIX      = 10,
  parameter int ASCII_MODE = 1
) (
  input  logic [7:0] dato,
  output logic [4:0] value,
  output logic       is_digit,
  output logic       is_minus
);

  always_comb begin
    value    = 5'd31;
    is_minus = 1'b0;
    if (ASCII_MODE != 0) begin
      if (dato >= CHAR_0 && dato <= CHAR_0 + 8'd9) begin
        value = 5'(dato - CHAR_0);
      end else if (dato >= CHAR_A && dato <= CHAR_A + 8'd5) begin
        value = 5'(dato - CHAR_A + 8'd10);
      end else if (dato >= CHAR_a && dato <= CHAR_a + 8'd5) begin
        value = 5'(dato - CHAR_a + 8'd10);
      end
      is_minus = (dato == CHAR_MINUS);
    end else if (dato < 8'd32) begin
      value = dato[4:0];
    end
    is_digit = (value < 5'(RADIX));
  end

endmodule

// File: rtl/digit_stream_accumulator.sv
// Turns an MSB-first stream of digit bytes into a binary integer using
// Horner's rule, closed by a terminator strobe; reports invalid input/overflow.
module digit_stream_accumulator
  import dsa_pkg::*;
#(
  parameter int RESULT_W   = 32,
  parameter int RADIX      = 10,
  parameter int MAX_DIGITS = 10,
  parameter int ASCII_MODE = 1,
  parameter int SIGNED     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          dato,
  input  logic                num_ready,
  input  logic                fin,
  output logic [RESULT_W-1:0] resultado,
  output logic                done,
  output logic                error,
  output logic [4:0]          digit_count,
  output state_e              dbg_state
);

  localparam int ACC_W = RESULT_W + 8;
  localparam logic [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] RADIX_A = ACC_W'(RADIX);
  localparam logic [ACC_W-1:0] LIM_NEG = ONE << (RESULT_W - 1);
  localparam logic [ACC_W-1:0] LIM_POS = (SIGNED != 0) ? (LIM_NEG - ONE)
                                                       : ((ONE << RESULT_W) - ONE);
  localparam logic [4:0] MAX_D = 5'(MAX_DIGITS);

  state_e              state_q, state_d;
  logic                nr_q, nr_d, nr_prev_q, nr_prev_d;
  logic                fin_q, fin_d, fin_prev_q, fin_prev_d;
  logic [7:0]          dato_q, dato_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_next, limit;
  logic                sign_q, sign_d, err_q, err_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [RESULT_W-1:0] resultado_q, resultado_d;
  logic                done_q, done_d, error_q, error_d;
  logic                byte_stb, fin_stb;
  logic [4:0]          dig_value;
  logic                is_digit, is_minus;

  // Inputs are registered once; strobes come from the registered pair so a
  // held level produces a single event.
  assign byte_stb = nr_q & ~nr_prev_q;
  assign fin_stb  = fin_q & ~fin_prev_q;

  digit_decoder #(
    .RADIX     (RADIX),
    .ASCII_MODE(ASCII_MODE)
  ) u_dec (
    .dato    (dato_q),
    .value   (dig_value),
    .is_digit(is_digit),
    .is_minus(is_minus)
  );

  always_comb begin
    state_d     = state_q;
    nr_d        = num_ready;
    nr_prev_d   = nr_q;
    fin_d       = fin;
    fin_prev_d  = fin_q;
    dato_d      = dato;
    acc_d       = acc_q;
    sign_d      = sign_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    resultado_d = resultado_q;
    done_d      = 1'b0;
    error_d     = error_q;
    acc_next    = acc_q * RADIX_A + {{(ACC_W-5){1'b0}}, dig_value};
    limit       = sign_q ? LIM_NEG : LIM_POS;

    case (state_q)
      IDLE, ACCUM: begin
        if (byte_stb) begin
          state_d = ACCUM;
          if (is_minus && (SIGNED != 0) && (cnt_q == 5'd0) && !sign_q) begin
            sign_d = 1'b1;
          end else if (!is_digit) begin
            err_d = 1'b1;
          end else begin
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
            // Once any error is latched the accumulator stays frozen.
            if ((cnt_q >= MAX_D) || (acc_next > limit)) begin
              err_d = 1'b1;
            end else if (!err_q) begin
              acc_d = acc_next;
            end
          end
        end
        if (fin_stb) begin
          state_d = EMIT;
          if ((state_q == IDLE) && !byte_stb) err_d = 1'b1;
        end
      end
      EMIT: begin
        if (err_q) resultado_d = '0;
        else if (sign_q) resultado_d = -acc_q[RESULT_W-1:0];
        else resultado_d = acc_q[RESULT_W-1:0];
        error_d = err_q;
        done_d  = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        acc_d   = '0;
        sign_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      nr_q        <= 1'b0;
      nr_prev_q   <= 1'b0;
      fin_q       <= 1'b0;
      fin_prev_q  <= 1'b0;
      dato_q      <= '0;
      acc_q       <= '0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      resultado_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nr_q        <= nr_d;
      nr_prev_q   <= nr_prev_d;
      fin_q       <= fin_d;
      fin_prev_q  <= fin_prev_d;
      dato_q      <= dato_d;
      acc_q       <= acc_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      resultado_q <= resultado_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign resultado   = resultado_q;
  assign done        = done_q;
  assign error       = error_q;
  assign digit_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_digit_stream_accumulator.sv
// Directed bench for digit_stream_accumulator: a default decimal instance, a
// signed instance and a 16-bit hex instance share one input stream.
module tb_digit_stream_accumulator;
  import dsa_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] dato = 8'h00;
  logic num_ready = 1'b0;
  logic fin = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] d_res, s_res;
  logic [15:0] h_res;
  logic        d_done, d_err, s_done, s_err, h_done, h_err;
  logic [4:0]  d_cnt, s_cnt, h_cnt;
  state_e      d_st, s_st, h_st;

  digit_stream_accumulator u_dut (
    .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready), .fin(fin),
    .resultado(d_res), .done(d_done), .error(d_err), .digit_count(d_cnt),
    .dbg_state(d_st)
  );

  digit_stream_accumulator #(.SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready), .fin(fin),
    .resultado(s_res), .done(s_done), .error(s_err), .digit_count(s_cnt),
    .dbg_state(s_st)
  );

  digit_stream_accumulator #(.RADIX(16), .RESULT_W(16)) u_hex (
    .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready), .fin(fin),
    .resultado(h_res), .done(h_done), .error(h_err), .digit_count(h_cnt),
    .dbg_state(h_st)
  );

  int checks = 0;
  int errors = 0;
  int d_done_cnt = 0;

  always @(negedge clk) if (d_done === 1'b1) d_done_cnt++;

  function automatic logic done_of(input int which);
    case (which)
      0: return d_done;
      1: return s_done;
      default: return h_done;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dato = b;
    num_ready = 1'b1;
    repeat (4) @(negedge clk);
    num_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Raises fin (optionally together with num_ready) and records done for 8
  // clocks; hist[i] is done sampled just after the i-th posedge.
  task automatic pulse_fin(input int which, input logic with_byte,
                           output logic [8:1] hist);
    @(negedge clk);
    fin = 1'b1;
    if (with_byte) num_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      hist[i] = done_of(which);
    end
    fin = 1'b0;
    num_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (d_res !== 32'd0) begin errors++; $display("FAIL reset_res got %0h want 0", d_res); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", d_done); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", d_err); end
    checks++; if (d_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", d_cnt); end
    checks++; if (d_st !== IDLE) begin errors++; $display("FAIL reset_state got %b want %b", d_st, IDLE); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [8:1] hist;
    send_byte("1"); send_byte("2"); send_byte("3");
    checks++; if (d_cnt !== 5'd3) begin errors++; $display("FAIL basic_cnt got %0d want 3", d_cnt); end
    send_byte("4");
    pulse_fin(0, 1'b0, hist);
    checks++; if (hist !== 8'b0000_0100) begin errors++; $display("FAIL basic_done_timing got %b want 00000100", hist); end
    checks++; if (d_res !== 32'd1234) begin errors++; $display("FAIL basic_res got %0d want 1234", d_res); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", d_err); end
    checks++; if (d_cnt !== 5'd0) begin errors++; $display("FAIL basic_cnt_clear got %0d want 0", d_cnt); end
  endtask

  task automatic test_empty;
    logic [8:1] hist;
    pulse_fin(0, 1'b0, hist);
    checks++; if (hist !== 8'b0000_0100) begin errors++; $display("FAIL empty_done got %b want 00000100", hist); end
    checks++; if (d_res !== 32'd0) begin errors++; $display("FAIL empty_res got %0d want 0", d_res); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL empty_err got %b want 1", d_err); end
  endtask

  task automatic test_held_level;
    logic [8:1] hist;
    @(negedge clk);
    dato = "5";
    num_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (d_cnt !== 5'd1) begin errors++; $display("FAIL held_cnt got %0d want 1", d_cnt); end
    num_ready = 1'b0;
    repeat (2) @(negedge clk);
    pulse_fin(0, 1'b0, hist);
    checks++; if (d_res !== 32'd5) begin errors++; $display("FAIL held_res got %0d want 5", d_res); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL held_err got %b want 0", d_err); end
  endtask

  task automatic test_invalid;
    logic [8:1] hist;
    send_byte("1"); send_byte("x"); send_byte("2");
    pulse_fin(0, 1'b0, hist);
    checks++; if (d_res !== 32'd0) begin errors++; $display("FAIL invalid_res got %0d want 0", d_res); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL invalid_err got %b want 1", d_err); end
  endtask

  task automatic test_same_cycle;
    logic [8:1] hist;
    send_byte("8");
    @(negedge clk);
    dato = "9";
    pulse_fin(0, 1'b1, hist);
    checks++; if (hist !== 8'b0000_0100) begin errors++; $display("FAIL same_cycle_done got %b want 00000100", hist); end
    checks++; if (d_res !== 32'd89) begin errors++; $display("FAIL same_cycle_res got %0d want 89", d_res); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err got %b want 0", d_err); end
  endtask

  task automatic test_max_digits;
    logic [8:1] hist;
    for (int i = 0; i < 11; i++) send_byte("0");
    checks++; if (d_cnt !== 5'd11) begin errors++; $display("FAIL maxd_cnt got %0d want 11", d_cnt); end
    pulse_fin(0, 1'b0, hist);
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL maxd_err got %b want 1", d_err); end
    checks++; if (d_res !== 32'd0) begin errors++; $display("FAIL maxd_res got %0d want 0", d_res); end
  endtask

  task automatic test_signed;
    logic [8:1] hist;
    send_byte("-"); send_byte("4"); send_byte("2");
    checks++; if (s_cnt !== 5'd2) begin errors++; $display("FAIL signed_cnt got %0d want 2", s_cnt); end
    pulse_fin(1, 1'b0, hist);
    checks++; if (hist !== 8'b0000_0100) begin errors++; $display("FAIL signed_done got %b want 00000100", hist); end
    checks++; if (s_res !== 32'hFFFF_FFD6) begin errors++; $display("FAIL signed_res got %0h want ffffffd6", s_res); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL signed_err got %b want 0", s_err); end
    send_byte("7");
    pulse_fin(1, 1'b0, hist);
    checks++; if (s_res !== 32'd7) begin errors++; $display("FAIL signed_next_res got %0h want 7", s_res); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL signed_next_err got %b want 0", s_err); end
  endtask

  task automatic test_hex;
    logic [8:1] hist;
    send_byte("F"); send_byte("f"); send_byte("0"); send_byte("1");
    pulse_fin(2, 1'b0, hist);
    checks++; if (h_res !== 16'hFF01) begin errors++; $display("FAIL hex_res got %0h want ff01", h_res); end
    checks++; if (h_err !== 1'b0) begin errors++; $display("FAIL hex_err got %b want 0", h_err); end
    send_byte("1"); send_byte("0"); send_byte("0"); send_byte("0"); send_byte("0");
    pulse_fin(2, 1'b0, hist);
    checks++; if (hist !== 8'b0000_0100) begin errors++; $display("FAIL hex_ovf_done got %b want 00000100", hist); end
    checks++; if (h_res !== 16'h0000) begin errors++; $display("FAIL hex_ovf_res got %0h want 0", h_res); end
    checks++; if (h_err !== 1'b1) begin errors++; $display("FAIL hex_ovf_err got %b want 1", h_err); end
  endtask

  task automatic test_reset_mid;
    logic [8:1] hist;
    int base;
    base = d_done_cnt;
    send_byte("1"); send_byte("2");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (d_cnt !== 5'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", d_cnt); end
    send_byte("3");
    checks++; if (d_done_cnt !== base) begin errors++; $display("FAIL rst_mid_no_done got %0d want %0d", d_done_cnt, base); end
    pulse_fin(0, 1'b0, hist);
    checks++; if (d_res !== 32'd3) begin errors++; $display("FAIL rst_mid_res got %0d want 3", d_res); end
    checks++; if (d_done_cnt !== base + 1) begin errors++; $display("FAIL rst_mid_done_cnt got %0d want %0d", d_done_cnt, base + 1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_held_level();
    test_invalid();
    test_same_cycle();
    test_max_digits();
    test_signed();
    test_hex();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
